// File: rtl/tdt_dmi_req_capture.sv
// Destination-domain DMI request stage: captures synchronized requests into a FIFO,
// issues them one at a time to the debug module and reports each completion.
module tdt_dmi_req_capture #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                      dst_clk,
    input  logic                      dst_rst,
    input  logic                      req_pulse,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [1:0]                req_op,
    output logic                      dm_req_vld,
    input  logic                      dm_req_rdy,
    output logic [ADDR_WIDTH-1:0]     dm_req_addr,
    output logic [DATA_WIDTH-1:0]     dm_req_wdata,
    output logic [1:0]                dm_req_op,
    input  logic                      dm_resp_vld,
    input  logic [DATA_WIDTH-1:0]     dm_resp_rdata,
    input  logic                      dm_resp_err,
    output logic                      resp_pulse,
    output logic [DATA_WIDTH-1:0]     resp_rdata,
    output logic [1:0]                resp_status,
    output logic                      busy_err,
    input  logic                      busy_clr,
    output logic [$clog2(DEPTH):0]    fifo_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_RESP,
        S_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [ADDR_WIDTH-1:0]   r_mem_addr  [DEPTH];
    logic [DATA_WIDTH-1:0]   r_mem_wdata [DEPTH];
    logic [1:0]              r_mem_op    [DEPTH];
    logic [PTR_W-1:0]        r_wptr;
    logic [PTR_W-1:0]        r_rptr;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_busy_err;
    logic [DATA_WIDTH-1:0]   r_resp_rdata;
    logic [1:0]              r_resp_status;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_empty;
    logic [1:0]              w_head_op;
    logic                    w_head_is_dm;
    logic                    w_req_vld;
    logic                    w_resp_load;
    logic [DATA_WIDTH-1:0]   w_resp_rdata_nxt;
    logic [1:0]              w_resp_status_nxt;

    // Fullness uses the registered count, so a pop in the same cycle never frees a slot.
    assign w_push       = req_pulse && (r_cnt != CNT_W'(DEPTH));
    assign w_empty      = (r_cnt == '0);
    assign w_head_op    = r_mem_op[r_rptr];
    assign w_head_is_dm = (w_head_op == 2'b01) || (w_head_op == 2'b10);

    always_ff @(posedge dst_clk) begin
        if (w_push) begin
            r_mem_addr[r_wptr]  <= req_addr;
            r_mem_wdata[r_wptr] <= req_wdata;
            r_mem_op[r_wptr]    <= req_op;
        end
    end

    always_ff @(posedge dst_clk) begin
        if (dst_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge dst_clk) begin
        if (dst_rst) begin
            r_busy_err <= 1'b0;
        end else if (req_pulse && !w_push) begin
            r_busy_err <= 1'b1;
        end else if (busy_clr) begin
            r_busy_err <= 1'b0;
        end
    end

    always_ff @(posedge dst_clk) begin
        if (dst_rst) begin
            r_state       <= S_IDLE;
            r_resp_rdata  <= '0;
            r_resp_status <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            if (w_resp_load) begin
                r_resp_rdata  <= w_resp_rdata_nxt;
                r_resp_status <= w_resp_status_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pop             = 1'b0;
        w_req_vld         = 1'b0;
        w_resp_load       = 1'b0;
        w_resp_rdata_nxt  = '0;
        w_resp_status_nxt = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_head_is_dm) begin
                        w_req_vld = 1'b1;
                        if (dm_req_rdy) begin
                            w_pop       = 1'b1;
                            w_state_nxt = S_WAIT_RESP;
                        end
                    end else begin
                        // nop and reserved ops complete locally without touching the DM
                        w_pop             = 1'b1;
                        w_resp_load       = 1'b1;
                        w_resp_status_nxt = (w_head_op == 2'b11) ? 2'b10 : 2'b00;
                        w_state_nxt       = S_RESP;
                    end
                end
            end
            S_WAIT_RESP: begin
                if (dm_resp_vld) begin
                    w_resp_load       = 1'b1;
                    w_resp_rdata_nxt  = dm_resp_rdata;
                    w_resp_status_nxt = {dm_resp_err, 1'b0};
                    w_state_nxt       = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign dm_req_vld   = w_req_vld;
    assign dm_req_addr  = r_mem_addr[r_rptr];
    assign dm_req_wdata = r_mem_wdata[r_rptr];
    assign dm_req_op    = w_head_op;
    assign resp_pulse   = (r_state == S_RESP);
    assign resp_rdata   = r_resp_rdata;
    assign resp_status  = r_resp_status;
    assign busy_err     = r_busy_err;
    assign fifo_cnt     = r_cnt;

endmodule

// File: tb/tb_tdt_dmi_req_capture.sv
// Table-driven bench for tdt_dmi_req_capture plus directed back-pressure and reset sequences.
module tb_tdt_dmi_req_capture;
    logic        clk;
    logic        rst;
    logic        req_pulse;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_op;
    logic        dm_req_vld;
    logic        dm_req_rdy;
    logic [6:0]  dm_req_addr;
    logic [31:0] dm_req_wdata;
    logic [1:0]  dm_req_op;
    logic        dm_resp_vld;
    logic [31:0] dm_resp_rdata;
    logic        dm_resp_err;
    logic        resp_pulse;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_status;
    logic        busy_err;
    logic        busy_clr;
    logic [1:0]  fifo_cnt;

    int total = 0;
    int bad   = 0;

    tdt_dmi_req_capture #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .DEPTH(2)) dut (
        .dst_clk(clk), .dst_rst(rst),
        .req_pulse(req_pulse), .req_addr(req_addr), .req_wdata(req_wdata), .req_op(req_op),
        .dm_req_vld(dm_req_vld), .dm_req_rdy(dm_req_rdy), .dm_req_addr(dm_req_addr),
        .dm_req_wdata(dm_req_wdata), .dm_req_op(dm_req_op),
        .dm_resp_vld(dm_resp_vld), .dm_resp_rdata(dm_resp_rdata), .dm_resp_err(dm_resp_err),
        .resp_pulse(resp_pulse), .resp_rdata(resp_rdata), .resp_status(resp_status),
        .busy_err(busy_err), .busy_clr(busy_clr), .fifo_cnt(fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        p;
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] wd;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        er;
        logic        bc;
        logic        e_vld;
        logic        e_rp;
        logic [1:0]  e_cnt;
        logic        e_busy;
        logic [31:0] e_rdata;
        logic [1:0]  e_st;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic p, input logic [1:0] op, input logic [6:0] addr,
                       input logic [31:0] wd, input logic rdy, input logic rv,
                       input logic [31:0] rd, input logic er, input logic bc,
                       input logic e_vld, input logic e_rp, input logic [1:0] e_cnt,
                       input logic e_busy, input logic [31:0] e_rdata, input logic [1:0] e_st);
        vec_t v;
        v.p = p; v.op = op; v.addr = addr; v.wd = wd; v.rdy = rdy; v.rv = rv;
        v.rd = rd; v.er = er; v.bc = bc; v.e_vld = e_vld; v.e_rp = e_rp;
        v.e_cnt = e_cnt; v.e_busy = e_busy; v.e_rdata = e_rdata; v.e_st = e_st;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_pulse = 0; req_addr = '0; req_wdata = '0; req_op = 2'b00;
        dm_req_rdy = 0; dm_resp_vld = 0; dm_resp_rdata = '0; dm_resp_err = 0; busy_clr = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        chk("rst_vld",    {31'd0, dm_req_vld},  32'd0);
        chk("rst_pulse",  {31'd0, resp_pulse},  32'd0);
        chk("rst_cnt",    {30'd0, fifo_cnt},    32'd0);
        chk("rst_busy",   {31'd0, busy_err},    32'd0);
        chk("rst_rdata",  resp_rdata,           32'd0);
        chk("rst_status", {30'd0, resp_status}, 32'd0);
        rst = 1'b0;

        //   p  op     addr   wd     rdy rv rd            er bc | vld rp cnt busy rdata         st
        // single read
        add(1, 2'b01, 7'h11, 32'h0, 1, 0, 32'h0,        0, 0,   1,  0, 1,  0,   32'h0,        2'b00);
        add(0, 2'b00, 7'h00, 32'h0, 1, 0, 32'h0,        0, 0,   0,  0, 0,  0,   32'h0,        2'b00);
        add(0, 2'b00, 7'h00, 32'h0, 1, 1, 32'hDEADBEEF, 0, 0,   0,  1, 0,  0,   32'hDEADBEEF, 2'b00);
        add(0, 2'b00, 7'h00, 32'h0, 0, 0, 32'h0,        0, 0,   0,  0, 0,  0,   32'hDEADBEEF, 2'b00);
        // local nop then reserved op
        add(1, 2'b00, 7'h05, 32'h0, 0, 0, 32'h0,        0, 0,   0,  0, 1,  0,   32'hDEADBEEF, 2'b00);
        add(1, 2'b11, 7'h06, 32'h0, 0, 0, 32'h0,        0, 0,   0,  1, 1,  0,   32'h0,        2'b00);
        add(0, 2'b00, 7'h00, 32'h0, 0, 0, 32'h0,        0, 0,   0,  0, 1,  0,   32'h0,        2'b00);
        add(0, 2'b00, 7'h00, 32'h0, 0, 0, 32'h0,        0, 0,   0,  1, 0,  0,   32'h0,        2'b10);
        add(0, 2'b00, 7'h00, 32'h0, 0, 0, 32'h0,        0, 0,   0,  0, 0,  0,   32'h0,        2'b10);
        // DM error, then stray responses outside WAIT_RESP
        add(1, 2'b10, 7'h22, 32'h55,0, 0, 32'h0,        0, 0,   1,  0, 1,  0,   32'h0,        2'b10);
        add(0, 2'b00, 7'h00, 32'h0, 1, 0, 32'h0,        0, 0,   0,  0, 0,  0,   32'h0,        2'b10);
        add(0, 2'b00, 7'h00, 32'h0, 0, 1, 32'h12345678, 1, 0,   0,  1, 0,  0,   32'h12345678, 2'b10);
        add(0, 2'b00, 7'h00, 32'h0, 0, 1, 32'h1,        0, 0,   0,  0, 0,  0,   32'h12345678, 2'b10);
        add(0, 2'b00, 7'h00, 32'h0, 0, 1, 32'h2,        0, 0,   0,  0, 0,  0,   32'h12345678, 2'b10);
        // overflow and busy_err set/clear priority
        add(1, 2'b01, 7'h01, 32'h0, 0, 0, 32'h0,        0, 0,   1,  0, 1,  0,   32'h12345678, 2'b10);
        add(1, 2'b01, 7'h02, 32'h0, 0, 0, 32'h0,        0, 0,   1,  0, 2,  0,   32'h12345678, 2'b10);
        add(1, 2'b01, 7'h03, 32'h0, 0, 0, 32'h0,        0, 0,   1,  0, 2,  1,   32'h12345678, 2'b10);
        add(1, 2'b01, 7'h04, 32'h0, 0, 0, 32'h0,        0, 1,   1,  0, 2,  1,   32'h12345678, 2'b10);
        add(0, 2'b00, 7'h00, 32'h0, 0, 0, 32'h0,        0, 1,   1,  0, 2,  0,   32'h12345678, 2'b10);
        // push at full with simultaneous pop is still dropped
        add(1, 2'b01, 7'h05, 32'h0, 1, 0, 32'h0,        0, 0,   0,  0, 1,  1,   32'h12345678, 2'b10);
        add(0, 2'b00, 7'h00, 32'h0, 0, 1, 32'hA5,       0, 0,   0,  1, 1,  1,   32'hA5,       2'b00);
        add(0, 2'b00, 7'h00, 32'h0, 0, 0, 32'h0,        0, 0,   1,  0, 1,  1,   32'hA5,       2'b00);
        add(0, 2'b00, 7'h00, 32'h0, 1, 0, 32'h0,        0, 0,   0,  0, 0,  1,   32'hA5,       2'b00);
        add(0, 2'b00, 7'h00, 32'h0, 0, 1, 32'h5A,       0, 0,   0,  1, 0,  1,   32'h5A,       2'b00);
        add(0, 2'b00, 7'h00, 32'h0, 0, 0, 32'h0,        0, 0,   0,  0, 0,  1,   32'h5A,       2'b00);
        add(0, 2'b00, 7'h00, 32'h0, 0, 0, 32'h0,        0, 1,   0,  0, 0,  0,   32'h5A,       2'b00);

        foreach (vecs[i]) begin
            req_pulse = vecs[i].p; req_op = vecs[i].op; req_addr = vecs[i].addr;
            req_wdata = vecs[i].wd; dm_req_rdy = vecs[i].rdy; dm_resp_vld = vecs[i].rv;
            dm_resp_rdata = vecs[i].rd; dm_resp_err = vecs[i].er; busy_clr = vecs[i].bc;
            step();
            chk($sformatf("v%0d_vld", i),    {31'd0, dm_req_vld},  {31'd0, vecs[i].e_vld});
            chk($sformatf("v%0d_pulse", i),  {31'd0, resp_pulse},  {31'd0, vecs[i].e_rp});
            chk($sformatf("v%0d_cnt", i),    {30'd0, fifo_cnt},    {30'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d_busy", i),   {31'd0, busy_err},    {31'd0, vecs[i].e_busy});
            chk($sformatf("v%0d_rdata", i),  resp_rdata,           vecs[i].e_rdata);
            chk($sformatf("v%0d_status", i), {30'd0, resp_status}, {30'd0, vecs[i].e_st});
        end
        idle_inputs();

        // back-pressure: write held for 5 cycles, popped only on the rdy cycle
        req_pulse = 1; req_op = 2'b10; req_addr = 7'h33; req_wdata = 32'hCAFEF00D;
        step();
        idle_inputs();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_vld", k),   {31'd0, dm_req_vld}, 32'd1);
            chk($sformatf("bp%0d_addr", k),  {25'd0, dm_req_addr}, 32'h33);
            chk($sformatf("bp%0d_wdata", k), dm_req_wdata, 32'hCAFEF00D);
            chk($sformatf("bp%0d_op", k),    {30'd0, dm_req_op}, 32'd2);
            chk($sformatf("bp%0d_cnt", k),   {30'd0, fifo_cnt}, 32'd1);
            step();
        end
        dm_req_rdy = 1;
        step();
        dm_req_rdy = 0;
        chk("bp_pop_cnt", {30'd0, fifo_cnt}, 32'd0);
        chk("bp_pop_vld", {31'd0, dm_req_vld}, 32'd0);
        dm_resp_vld = 1; dm_resp_rdata = 32'h77;
        step();
        idle_inputs();
        chk("bp_resp_pulse", {31'd0, resp_pulse}, 32'd1);
        chk("bp_resp_rdata", resp_rdata, 32'h77);
        step();

        // reset while WAIT_RESP with one entry queued
        req_pulse = 1; req_op = 2'b01; req_addr = 7'h44;
        step();
        chk("rs_vld", {31'd0, dm_req_vld}, 32'd1);
        req_addr = 7'h45; dm_req_rdy = 1;
        step();
        idle_inputs();
        chk("rs_wait_cnt", {30'd0, fifo_cnt}, 32'd1);
        chk("rs_wait_vld", {31'd0, dm_req_vld}, 32'd0);
        rst = 1;
        step();
        rst = 0;
        chk("rs_vld0",    {31'd0, dm_req_vld},  32'd0);
        chk("rs_pulse0",  {31'd0, resp_pulse},  32'd0);
        chk("rs_cnt0",    {30'd0, fifo_cnt},    32'd0);
        chk("rs_busy0",   {31'd0, busy_err},    32'd0);
        chk("rs_rdata0",  resp_rdata,           32'd0);
        chk("rs_status0", {30'd0, resp_status}, 32'd0);
        dm_resp_vld = 1; dm_resp_rdata = 32'h99;
        step();
        dm_resp_vld = 0;
        chk("late_pulse", {31'd0, resp_pulse}, 32'd0);
        chk("late_cnt",   {30'd0, fifo_cnt},   32'd0);
        step();
        chk("late_pulse2", {31'd0, resp_pulse}, 32'd0);
        chk("late_rdata",  resp_rdata,          32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule

// File: doc/tdt_dmi_req_capture.md
# tdt_dmi_req_capture

Destination-domain DMI request stage sitting directly downstream of the DMI pulse synchronizer. On each synchronized request strobe it samples the quasi-static DMI request bus held by the source side into a small FIFO. It issues queued requests one at a time to the debug module over a valid/ready handshake and collects the response. Each completion is reported as a registered result plus a single-cycle response strobe, which feeds the return pulse synchronizer.

## Interface
Parameters:
- ADDR_WIDTH, 7: DMI address width
- DATA_WIDTH, 32: DMI data width
- DEPTH, 2: request FIFO entries (power of two, ≥2)

Ports:
- dst_clk  in  1  block clock
- dst_rst  in  1  reset, synchronous, active-high
- req_pulse  in  1  single-cycle request strobe from the pulse synchronizer
- req_addr  in  ADDR_WIDTH  request address, stable while req_pulse is high
- req_wdata  in  DATA_WIDTH  request write data
- req_op  in  2  op code: 00 nop, 01 read, 10 write, 11 reserved
- dm_req_vld  out  1  request valid to the debug module
- dm_req_rdy  in  1  debug module accepts the request
- dm_req_addr  out  ADDR_WIDTH  FIFO head address
- dm_req_wdata  out  DATA_WIDTH  FIFO head write data
- dm_req_op  out  2  FIFO head op (only 01/10 are ever presented)
- dm_resp_vld  in  1  single-cycle response from the debug module
- dm_resp_rdata  in  DATA_WIDTH  read data
- dm_resp_err  in  1  debug module reports failure
- resp_pulse  out  1  single-cycle completion strobe toward the return synchronizer
- resp_rdata  out  DATA_WIDTH  completion data
- resp_status  out  2  00 ok, 10 failed/reserved op
- busy_err  out  1  sticky: a request was dropped because the FIFO was full
- busy_clr  in  1  clears busy_err
- fifo_cnt  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Push: req_pulse=1 with fifo_cnt<DEPTH writes {addr,wdata,op} at the write pointer. Fullness is judged on the registered count. A push at full is dropped even if a pop occurs in the same cycle, and busy_err is set.
- busy_err: a set and busy_clr in the same cycle -> set wins.
- Pointers wrap modulo DEPTH. Simultaneous push and pop leaves the count unchanged.
- dm_req_* are driven from the registered head entry. dm_req_vld has no combinational path from dm_req_rdy.
- FSM states are IDLE, WAIT_RESP and RESP.
  - IDLE, FIFO empty: stay in IDLE.
  - IDLE, head op 01/10: dm_req_vld=1. On dm_req_vld&dm_req_rdy, pop the head -> WAIT_RESP.
  - IDLE, head op 00/11: pop the head with no DM transaction. Load resp_rdata=0 and resp_status=00 (nop) or 10 (reserved) -> RESP.
  - WAIT_RESP: dm_req_vld=0. On dm_resp_vld, load resp_rdata=dm_resp_rdata and resp_status={dm_resp_err,1'b0} -> RESP.
  - RESP: resp_pulse=1 for this single cycle -> IDLE.
- resp_rdata/resp_status hold their value until the next completion.
- dm_resp_vld outside WAIT_RESP is ignored.
- Reset values: FSM IDLE, pointers and fifo_cnt 0, dm_req_vld 0, resp_pulse 0, resp_rdata 0, resp_status 00, busy_err 0. A reset mid-transaction discards queued and in-flight requests, and a late dm_resp_vld is then ignored.

## Timing
- req_pulse at cycle N into an empty FIFO while IDLE -> fifo_cnt=1 and dm_req_vld=1 at N+1.
- Handshake at cycle M -> WAIT_RESP at M+1. The next head is not presented until after RESP.
- dm_resp_vld at K -> resp_pulse=1 at K+1 -> IDLE at K+2, where the next dm_req_vld can assert.
- Local (nop/reserved) completion: pop at M, resp_pulse at M+1, IDLE at M+2.
- Consecutive resp_pulse strobes are therefore ≥2 cycles apart, as the return synchronizer requires.
- Minimum DM round trip: 3 cycles per request (IDLE, WAIT_RESP, RESP), with dm_resp_vld arriving the cycle after the handshake.

## Test plan
- Single read: push op=01, addr=0x11 at N. Require dm_req_vld at N+1 with rdy tied 1. Return dm_resp_vld with rdata=0xDEADBEEF, err=0 one cycle later. Require resp_pulse one cycle after that with resp_rdata=0xDEADBEEF, status=00.
- Back-pressure: push a write with dm_req_rdy=0 for 5 cycles. Require dm_req_vld held and addr/wdata/op stable, then a pop only on the rdy cycle.
- Overflow (DEPTH=2, rdy=0): three pushes -> fifo_cnt=2 and busy_err=1. Assert busy_clr together with a 4th dropped push -> busy_err stays 1. busy_clr alone -> busy_err=0.
- Local ops: push 00 then 11 -> no dm_req_vld. Require two resp_pulse strobes 2 cycles apart with status 00 then 10, resp_rdata=0.
- Error plus stray response: dm_resp_err=1 -> status=10. Drive dm_resp_vld while IDLE -> no resp_pulse.
- Reset in WAIT_RESP with 1 entry queued -> all outputs at reset values next cycle. A subsequent dm_resp_vld is ignored and fifo_cnt=0.
